// File: rtl/ssg_tone_array.sv
// ssg_tone_array: bank of NUM_CH square-wave tone generators sharing one
// prescaler, with a byte-wide register file and a time-multiplexed mixer
// that adds one channel per clock and emits a sample every NUM_CH clocks.
// Optional feature macro: SSG_TONE_ARRAY_LOGVOL_EN selects a 16-entry
// logarithmic volume table instead of linear volume.
module ssg_tone_array #(
  parameter int NUM_CH   = 6,
  parameter int PERIOD_W = 12,
  parameter int PRESCALE = 16,
`ifdef SSG_TONE_ARRAY_LOGVOL_EN
  localparam int AMP_MAX = 255,
`else
  localparam int AMP_MAX = 15,
`endif
  localparam int OUT_W   = $clog2(NUM_CH * AMP_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [7:0]        address,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic [NUM_CH-1:0] tone,
  output logic [OUT_W-1:0]  sound_out,
  output logic              sound_valid
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int PH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PERIOD_W-1:0] period_q [NUM_CH];
  logic [PERIOD_W-1:0] period_d [NUM_CH];
  logic [NUM_CH-1:0]   en_q, en_d;
  logic [3:0]          vol_q [NUM_CH];
  logic [3:0]          vol_d [NUM_CH];
  logic [7:0]          rdata_q, rdata_d;
  logic [15:0]         per_ext;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic                tick;
  logic [NUM_CH-1:0]   tone_q;
  logic [OUT_W-1:0]    term [NUM_CH];
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [OUT_W-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0]    sound_q, sound_d;
  logic                valid_q, valid_d;
  logic [OUT_W-1:0]    frame_sum;
  logic                last_phase;

  // Volume code to amplitude.
  function automatic logic [7:0] amp(input logic [3:0] v);
`ifdef SSG_TONE_ARRAY_LOGVOL_EN
    case (v)
      4'd0:    amp = 8'd0;
      4'd1:    amp = 8'd2;
      4'd2:    amp = 8'd3;
      4'd3:    amp = 8'd4;
      4'd4:    amp = 8'd6;
      4'd5:    amp = 8'd8;
      4'd6:    amp = 8'd11;
      4'd7:    amp = 8'd16;
      4'd8:    amp = 8'd23;
      4'd9:    amp = 8'd32;
      4'd10:   amp = 8'd45;
      4'd11:   amp = 8'd64;
      4'd12:   amp = 8'd90;
      4'd13:   amp = 8'd128;
      4'd14:   amp = 8'd180;
      default: amp = 8'd255;
    endcase
`else
    amp = {4'd0, v};
`endif
  endfunction

  // Register file: decode write and readback; unmatched addresses read 0xFF.
  always_comb begin
    period_d = period_q;
    en_d     = en_q;
    vol_d    = vol_q;
    rdata_d  = 8'hFF;
    per_ext  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      per_ext = 16'(period_q[c]);
      if (address == 8'(3 * c))     rdata_d = per_ext[7:0];
      if (address == 8'(3 * c + 1)) rdata_d = per_ext[15:8];
      if (address == 8'(3 * c + 2)) rdata_d = {en_q[c], 3'b000, vol_q[c]};
      if (wr) begin
        if (address == 8'(3 * c)) period_d[c][7:0] = wdata;
        if (address == 8'(3 * c + 1)) begin
          per_ext[15:8] = wdata;
          period_d[c]   = per_ext[PERIOD_W-1:0];
        end
        if (address == 8'(3 * c + 2)) begin
          en_d[c]  = wdata[7];
          vol_d[c] = wdata[3:0];
        end
      end
    end
  end

  // Register file and readback state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        period_q[c] <= '0;
        vol_q[c]    <= '0;
      end
      en_q    <= '0;
      rdata_q <= '0;
    end else begin
      period_q <= period_d;
      vol_q    <= vol_d;
      en_q     <= en_d;
      rdata_q  <= rdata_d;
    end
  end

  // Shared prescaler: tick in the last cycle of every PRESCALE-cycle window.
  always_comb begin
    tick    = (presc_q == PS_W'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PERIOD_W-1:0] cnt_q, cnt_d, eff_m1;
      logic                tone_bit_q, tone_bit_d;

      // Tone counter: '>=' lets a shrunk period toggle on the next tick.
      always_comb begin
        eff_m1     = (period_q[gi] == '0) ? '0 : period_q[gi] - 1'b1;
        cnt_d      = cnt_q;
        tone_bit_d = tone_bit_q;
        if (tick) begin
          if (cnt_q >= eff_m1) begin
            cnt_d      = '0;
            tone_bit_d = ~tone_bit_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Tone counter and square-wave state.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q      <= '0;
          tone_bit_q <= 1'b0;
        end else begin
          cnt_q      <= cnt_d;
          tone_bit_q <= tone_bit_d;
        end
      end

      assign tone_q[gi] = tone_bit_q;
      assign term[gi]   = (tone_bit_q & en_q[gi]) ? OUT_W'(amp(vol_q[gi])) : '0;
    end
  endgenerate

  // Mixer: one channel per clock; the last phase publishes the frame sum.
  always_comb begin
    frame_sum  = ((phase_q == '0) ? '0 : acc_q) + term[phase_q];
    last_phase = (phase_q == PH_W'(NUM_CH - 1));
    acc_d      = frame_sum;
    phase_d    = last_phase ? '0 : phase_q + 1'b1;
    sound_d    = last_phase ? frame_sum : sound_q;
    valid_d    = last_phase;
  end

  // Mixer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      acc_q   <= '0;
      sound_q <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      sound_q <= sound_d;
      valid_q <= valid_d;
    end
  end

  assign rdata       = rdata_q;
  assign tone        = tone_q;
  assign sound_out   = sound_q;
  assign sound_valid = valid_q;

endmodule

// File: tb/tb_ssg_tone_array.sv
// Testbench for ssg_tone_array: cycle-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_ssg_tone_array;
  localparam int NUM_CH   = 6;
  localparam int PERIOD_W = 12;
  localparam int PRESCALE = 16;
`ifdef SSG_TONE_ARRAY_LOGVOL_EN
  localparam int AMP_MAX  = 255;
  localparam int EXP_ONE  = 255;
  localparam int EXP_ALL  = 1530;
`else
  localparam int AMP_MAX  = 15;
  localparam int EXP_ONE  = 15;
  localparam int EXP_ALL  = 90;
`endif
  localparam int OUT_W    = $clog2(NUM_CH * AMP_MAX + 1);

  logic              clk;
  logic              reset;
  logic              wr;
  logic [7:0]        address;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic [NUM_CH-1:0] tone;
  logic [OUT_W-1:0]  sound_out;
  logic              sound_valid;

  ssg_tone_array #(
    .NUM_CH  (NUM_CH),
    .PERIOD_W(PERIOD_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .tone       (tone),
    .sound_out  (sound_out),
    .sound_valid(sound_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_per [NUM_CH];
  int m_en  [NUM_CH];
  int m_vol [NUM_CH];
  int m_cnt [NUM_CH];
  bit m_tone[NUM_CH];
  int m_cyc;
  int m_sum;
  int exp_sound;
  int exp_valid;
  int exp_rdata;
  bit model_ok = 1'b0;

  function automatic int amp_f(input int v);
`ifdef SSG_TONE_ARRAY_LOGVOL_EN
    int tbl[16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 180, 255};
    return tbl[v];
`else
    return v;
`endif
  endfunction

  function automatic int read_f(input int a);
    int c;
    if (a >= 3 * NUM_CH) return 255;
    c = a / 3;
    case (a % 3)
      0:       return m_per[c] % 256;
      1:       return m_per[c] / 256;
      default: return m_en[c] * 128 + m_vol[c];
    endcase
  endfunction

  task automatic model_step();
    int ph, term, eff, c;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_per[i] = 0; m_en[i] = 0; m_vol[i] = 0; m_cnt[i] = 0; m_tone[i] = 0;
      end
      m_cyc = 0; m_sum = 0; exp_sound = 0; exp_valid = 0; exp_rdata = 0;
      model_ok = 1'b1;
    end else begin
      // mixer samples channel (cycle mod NUM_CH) as it stood before this edge
      ph   = m_cyc % NUM_CH;
      term = (m_tone[ph] && m_en[ph] != 0) ? amp_f(m_vol[ph]) : 0;
      m_sum = (ph == 0) ? term : m_sum + term;
      exp_valid = (ph == NUM_CH - 1) ? 1 : 0;
      if (exp_valid != 0) exp_sound = m_sum;
      exp_rdata = read_f(int'(address));
      // tone ticks use the period as it stood before any write this cycle
      if (m_cyc % PRESCALE == PRESCALE - 1) begin
        for (int i = 0; i < NUM_CH; i++) begin
          eff = (m_per[i] == 0) ? 1 : m_per[i];
          if (m_cnt[i] >= eff - 1) begin
            m_cnt[i] = 0;
            m_tone[i] = ~m_tone[i];
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (wr && int'(address) < 3 * NUM_CH) begin
        c = int'(address) / 3;
        case (int'(address) % 3)
          0: m_per[c] = (m_per[c] / 256) * 256 + int'(wdata);
          1: m_per[c] = (m_per[c] % 256) + (int'(wdata) % (1 << (PERIOD_W - 8))) * 256;
          default: begin
            m_en[c]  = int'(wdata[7]);
            m_vol[c] = int'(wdata[3:0]);
          end
        endcase
      end
      m_cyc++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    logic [NUM_CH-1:0] et;
    @(negedge clk);
    if (model_ok) begin
      for (int i = 0; i < NUM_CH; i++) et[i] = m_tone[i];
      chk("model_tone", 32'(tone), 32'(et));
      chk("model_sound_out", 32'(sound_out), exp_sound);
      chk("model_sound_valid", 32'(sound_valid), exp_valid);
      chk("model_rdata", 32'(rdata), exp_rdata);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    wr = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr_reg(input int a, input int d);
    wr = 1'b1;
    address = 8'(a);
    wdata = 8'(d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_toggle(input int ch, input int maxcyc, output int n, output bit ok);
    logic start;
    start = tone[ch];
    ok = 1'b0;
    n = 0;
    for (int i = 1; i <= maxcyc; i++) begin
      @(negedge clk);
      if (tone[ch] !== start) begin
        n = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_interval(input int ch, input string name, input int exp);
    int n;
    bit ok;
    wait_toggle(ch, 4 * exp + 8, n, ok);
    if (!ok) chk({name, "_first_edge"}, 0, 1);
    wait_toggle(ch, 4 * exp + 8, n, ok);
    chk(name, ok ? n : -1, exp);
  endtask

  task automatic scan_sound(input int ncyc, output int mx, output int mn);
    mx = -1;
    mn = 1 << 30;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sound_valid === 1'b1) begin
        if (int'(sound_out) > mx) mx = int'(sound_out);
        if (int'(sound_out) < mn) mn = int'(sound_out);
      end
    end
  endtask

  initial begin
    int  mx, mn, n;
    bit  ok;
    reset = 1'b1;
    wr = 1'b0;
    address = 8'd2;
    wdata = 8'd0;
    @(negedge clk);

    // 1: reset state and readback after reset
    do_reset(4);
    chk("t1_tone", 32'(tone), 0);
    chk("t1_sound_out", 32'(sound_out), 0);
    chk("t1_sound_valid", 32'(sound_valid), 0);
    chk("t1_rdata_in_reset", 32'(rdata), 0);
    @(negedge clk);
    chk("t1_rdata_addr2", 32'(rdata), 0);

    // 2: ch0 period 1, enabled, full volume
    wr_reg(0, 8'h01);
    wr_reg(1, 8'h00);
    wr_reg(2, 8'h8F);
    measure_interval(0, "t2_toggle_period", 16);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sound_valid === 1'b1) ok = 1'b1;
    end
    n = -1;
    for (int i = 1; i <= 20 && ok; i++) begin
      @(negedge clk);
      if (sound_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("t2_valid_period", n, 6);
    scan_sound(120, mx, mn);
    chk("t2_sound_high", mx, EXP_ONE);
    chk("t2_sound_low", mn, 0);

    // 3: period 0 behaves as 1; disabled channel still toggles but is silent
    wr_reg(0, 8'h00);
    measure_interval(0, "t3_toggle_period0", 16);
    wr_reg(2, 8'h0F);
    repeat (8) @(negedge clk);
    scan_sound(96, mx, mn);
    chk("t3_disabled_max", mx, 0);
    wait_toggle(0, 40, n, ok);
    chk("t3_disabled_toggles", 32'(ok), 1);

    // 4: all channels period 2, vol 15, enabled, aligned by a fresh reset
    address = 8'd0;
    do_reset(2);
    for (int c = 0; c < NUM_CH; c++) wr_reg(3 * c, 2);
    for (int c = 0; c < NUM_CH; c++) wr_reg(3 * c + 2, 8'h8F);
    measure_interval(5, "t4_toggle_period", 32);
    scan_sound(200, mx, mn);
    chk("t4_sound_peak", mx, EXP_ALL);
    chk("t4_sound_low", mn, 0);

    // 5: out-of-range address and unused period bits
    wr_reg(18, 8'h55);
    address = 8'd18;
    @(negedge clk);
    chk("t5_rdata_oob", 32'(rdata), 32'hFF);
    address = 8'd17;
    @(negedge clk);
    chk("t5_rdata_ch5_ctrl", 32'(rdata), 32'h8F);
    wr_reg(1, 8'hFF);
    address = 8'd1;
    @(negedge clk);
    chk("t5_rdata_period_hi", 32'(rdata), 32'h0F);

    // 6: shrinking the period below the running count toggles on next tick
    wr_reg(3, 8'h00);
    wr_reg(4, 8'h01);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (m_cnt[1] == 'h50) ok = 1'b1;
    end
    chk("t6_reach_count", 32'(ok), 1);
    wr_reg(3, 8'h02);
    wr_reg(4, 8'h00);
    wait_toggle(1, 3 * PRESCALE, n, ok);
    chk("t6_shrink_toggle", 32'(ok && n <= PRESCALE + 1), 1);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
